// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (read-only) and the data port (loads/stores).
// One transaction at a time runs through IDLE -> CMD -> WAIT -> RESP.
// Data normally wins arbitration; a starvation counter forces fetch to win
// after STARVE_LIMIT consecutive losses. if_flush drops an in-flight fetch.
//
// Ports:
//   clk, reset (sync, active-low)
//   if_req/if_addr -> if_ready, if_flush, if_rvalid/if_rdata
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_ready, d_done/d_rdata
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb -> memory, mem_rdata <- memory
//   busy: high in every state except IDLE
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  input  logic                    if_flush,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ready,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 4;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   owner_if;
  logic                   dropped;
  logic [CNT_WIDTH-1:0]   lat_cnt;
  logic [CNT_WIDTH-1:0]   starve_cnt;
  logic [DATA_WIDTH-1:0]  resp_q;
  logic [DATA_WIDTH-1:0]  if_rdata_q;
  logic                   grant_if;
  logic                   grant_d;
  logic                   flush_hit;
  logic                   if_deliver;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and arbitration
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (reset) begin
          grant_d  = d_req && (!if_req || (starve_cnt != CNT_WIDTH'(STARVE_LIMIT)));
          grant_if = if_req && !grant_d;
        end
        if (grant_d || grant_if) state_nxt = S_CMD;
      end
      S_CMD:   state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign if_ready = grant_if;
  assign d_ready  = grant_d;
  assign busy     = (state != S_IDLE);

  // A flush seen in the RESP cycle itself must still suppress the pulse, so
  // the fetch response is presented combinationally from the captured word.
  assign flush_hit  = owner_if && if_flush && (state != S_IDLE);
  assign if_deliver = (state == S_RESP) && owner_if && !dropped && !flush_hit;
  assign if_rvalid  = if_deliver;
  assign if_rdata   = if_deliver ? resp_q : if_rdata_q;

  // Command latch, latency counter, responses and starvation tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_if   <= 1'b0;
      dropped    <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      resp_q     <= '0;
      if_rdata_q <= '0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      mem_en <= 1'b0;
      d_done <= 1'b0;

      if (grant_if || grant_d) begin
        owner_if  <= grant_if;
        dropped   <= 1'b0;
        mem_en    <= 1'b1;
        mem_we    <= grant_d && d_we;
        mem_addr  <= grant_if ? if_addr : d_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        mem_wstrb <= grant_d ? d_wstrb : STRB_WIDTH'(0);
      end else if (flush_hit) begin
        dropped <= 1'b1;
      end

      if (state == S_CMD) begin
        lat_cnt <= CNT_WIDTH'(MEM_LATENCY - 1);
      end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - CNT_WIDTH'(1);
      end

      // Capture edge: memory word is valid exactly MEM_LATENCY cycles after mem_en
      if ((state == S_WAIT) && (lat_cnt == '0)) begin
        if (owner_if) begin
          resp_q <= mem_rdata;
        end else begin
          d_done <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end
      end

      if (if_deliver) if_rdata_q <= resp_q;

      if (state == S_IDLE) begin
        if (grant_if || !if_req) begin
          starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != CNT_WIDTH'(STARVE_LIMIT))) begin
          starve_cnt <= starve_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
